// File: rtl/multi_sprite_plotter.sv
// Frame-synchronous multi-sprite plotter: on each frame tick it erases every sprite's
// previous rectangle and redraws it at its latched position, one pixel per clock.
module multi_sprite_plotter #(
  parameter int NUM_SPRITES = 2,
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int FRAME_DIV   = 833333,
  parameter int BG_COLOUR   = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_SPRITES*X_W-1:0]      sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0]      sprite_y,
  input  logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour,
  input  logic [NUM_SPRITES-1:0]          sprite_valid,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour,
  output logic                            plot,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CW    = $clog2(SPR_W + 1);
  localparam int RW    = $clog2(SPR_H + 1);
  localparam int FW    = $clog2(FRAME_DIV + 1);

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
  localparam logic [CW-1:0]       COL_LAST  = CW'(SPR_W - 1);
  localparam logic [RW-1:0]       ROW_LAST  = RW'(SPR_H - 1);
  localparam logic [FW-1:0]       FCNT_LAST = FW'(FRAME_DIV - 1);
  localparam logic [X_W:0]        SCR_W     = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]        SCR_H     = (Y_W+1)'(SCREEN_H);
  localparam logic [COLOUR_W-1:0] BG        = COLOUR_W'(BG_COLOUR);

  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, NEXT, DONE} state_t;

  state_t               state, state_nxt;
  logic [FW-1:0]        fcnt;
  logic                 tick;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [CW-1:0]        col, col_nxt;
  logic [RW-1:0]        row, row_nxt;
  logic                 last_pix;

  logic [X_W-1:0]       new_x      [NUM_SPRITES];
  logic [Y_W-1:0]       new_y      [NUM_SPRITES];
  logic [COLOUR_W-1:0]  new_colour [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] new_valid;
  logic [X_W-1:0]       old_x      [NUM_SPRITES];
  logic [Y_W-1:0]       old_y      [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] drawn;

  logic [X_W-1:0]       base_x;
  logic [Y_W-1:0]       base_y;
  logic [COLOUR_W-1:0]  src_colour;
  logic [X_W:0]         sum_x;
  logic [Y_W:0]         sum_y;
  logic                 drawing;
  logic [X_W-1:0]       x_p0;
  logic [Y_W-1:0]       y_p0;
  logic [COLOUR_W-1:0]  colour_p0;
  logic                 vld_p0;

  function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
    return (px < SCR_W) && (py < SCR_H);
  endfunction

  function automatic state_t dispatch(input logic was_drawn, input logic want);
    if (was_drawn) return ERASE;
    if (want) return DRAW;
    return NEXT;
  endfunction

  assign tick     = (fcnt == FCNT_LAST);
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    col_nxt   = col;
    row_nxt   = row;
    case (state)
      IDLE:  if (tick && enable) state_nxt = LATCH;
      LATCH: begin
        idx_nxt   = '0;
        col_nxt   = '0;
        row_nxt   = '0;
        state_nxt = dispatch(drawn[0], sprite_valid[0]);
      end
      ERASE, DRAW: begin
        if (last_pix) begin
          col_nxt   = '0;
          row_nxt   = '0;
          state_nxt = (state == ERASE && new_valid[idx]) ? DRAW : NEXT;
        end else if (col == COL_LAST) begin
          col_nxt = '0;
          row_nxt = row + RW'(1);
        end else begin
          col_nxt = col + CW'(1);
        end
      end
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = dispatch(drawn[idx_nxt], new_valid[idx_nxt]);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel stage p0: address and colour of the pixel the next cycle presents.
  // Leaving LATCH the snapshot registers are still loading, so read the inputs.
  always_comb begin
    base_x     = '0;
    base_y     = '0;
    src_colour = BG;
    if (state_nxt == ERASE) begin
      base_x = old_x[idx_nxt];
      base_y = old_y[idx_nxt];
    end else if (state == LATCH) begin
      base_x     = sprite_x[X_W-1:0];
      base_y     = sprite_y[Y_W-1:0];
      src_colour = sprite_colour[COLOUR_W-1:0];
    end else begin
      base_x     = new_x[idx_nxt];
      base_y     = new_y[idx_nxt];
      src_colour = new_colour[idx_nxt];
    end
    sum_x     = {1'b0, base_x} + (X_W+1)'(col_nxt);
    sum_y     = {1'b0, base_y} + (Y_W+1)'(row_nxt);
    drawing   = (state_nxt == ERASE) || (state_nxt == DRAW);
    vld_p0    = drawing && on_screen(sum_x, sum_y);
    x_p0      = drawing ? sum_x[X_W-1:0] : '0;
    y_p0      = drawing ? sum_y[Y_W-1:0] : '0;
    colour_p0 = drawing ? src_colour : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fcnt       <= '0;
      idx        <= '0;
      col        <= '0;
      row        <= '0;
      drawn      <= '0;
      new_valid  <= '0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        new_x[i]      <= '0;
        new_y[i]      <= '0;
        new_colour[i] <= '0;
        old_x[i]      <= '0;
        old_y[i]      <= '0;
      end
    end else begin
      fcnt       <= tick ? '0 : fcnt + FW'(1);
      state      <= state_nxt;
      idx        <= idx_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
      // Output stage p1: registered pixel toward the framebuffer.
      x          <= x_p0;
      y          <= y_p0;
      colour     <= colour_p0;
      plot       <= vld_p0;
      if (tick && state != IDLE) overrun <= 1'b1;
      if (state == LATCH) begin
        new_valid <= sprite_valid;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          new_x[i]      <= sprite_x[i*X_W +: X_W];
          new_y[i]      <= sprite_y[i*Y_W +: Y_W];
          new_colour[i] <= sprite_colour[i*COLOUR_W +: COLOUR_W];
        end
      end
      if (state == ERASE && last_pix) drawn[idx] <= 1'b0;
      if (state == DRAW && last_pix) begin
        old_x[idx] <= new_x[idx];
        old_y[idx] <= new_y[idx];
        drawn[idx] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/multi_sprite_plotter.md
# multi_sprite_plotter

Frame-synchronous plotter for several rectangular sprites, replacing the single-sprite movement datapath feeding `vga_adapter`. It has a built-in frame-rate divider. On each frame tick it snapshots every sprite's position, colour and valid bit. It then walks the sprites in index order, erasing each one's previous rectangle with the background colour and redrawing it at its new position, one pixel per clock. Output `x`/`y`/`colour`/`plot` connect directly to `vga_adapter`. Movement and firing logic only supply coordinates.

## Interface
- `NUM_SPRITES`, 2: number of sprite channels (1–8).
- `SPR_W`, 8: sprite width in pixels (power of two not required).
- `SPR_H`, 8: sprite height in pixels.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `COLOUR_W`, 3: colour width.
- `SCREEN_W`, 160: visible width; pixels with x ≥ SCREEN_W are clipped.
- `SCREEN_H`, 120: visible height; pixels with y ≥ SCREEN_H are clipped.
- `FRAME_DIV`, 833333: clocks per frame (60 Hz at 50 MHz).
- `BG_COLOUR`, 0: erase colour.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: allows new frames to start.
- `sprite_x` in NUM_SPRITES*X_W: packed x positions; sprite i occupies bits [i*X_W +: X_W].
- `sprite_y` in NUM_SPRITES*Y_W: packed y positions.
- `sprite_colour` in NUM_SPRITES*COLOUR_W: packed colours.
- `sprite_valid` in NUM_SPRITES: sprite i is to be shown.
- `x` out X_W, `y` out Y_W, `colour` out COLOUR_W: pixel to write.
- `plot` out 1: write strobe for `vga_adapter`.
- `busy` out 1: high from LATCH through DONE.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `overrun` out 1: sticky; set when a tick arrives while busy.

## Operation
- **Frame counter** `fcnt`:
  - Counts 0..FRAME_DIV-1 continuously from reset, regardless of `enable`.
  - Internal `tick` fires when fcnt == FRAME_DIV-1.
- **States:** IDLE, LATCH, ERASE, DRAW, NEXT, DONE.
- **IDLE:** on tick with `enable`=1, go to LATCH. A tick with `enable`=0 is ignored.
- **LATCH (1 cycle):**
  - Snapshot all `sprite_*` inputs into `new_*` registers.
  - Set index i=0 and pixel counters col=row=0.
  - Dispatch on sprite i, as below.
- **Dispatch rule (from LATCH or NEXT):**
  - `drawn[i]` set → ERASE.
  - Else `new_valid[i]` set → DRAW.
  - Else → NEXT.
- **ERASE (SPR_W*SPR_H cycles):**
  - Issue pixel (`old_x[i]`+col, `old_y[i]`+row) with colour BG_COLOUR.
  - Scan is row-major: col increments first; at col == SPR_W-1 it wraps to 0 and row increments.
  - After the last pixel: clear `drawn[i]`, reset counters, then go to DRAW if `new_valid[i]`, else NEXT.
- **DRAW (SPR_W*SPR_H cycles):**
  - Same scan, using `new_x[i]`/`new_y[i]` and `new_colour[i]`.
  - After the last pixel: `old_x[i]`/`old_y[i]` ← new values, set `drawn[i]`, go to NEXT.
- **NEXT (1 cycle):** if i == NUM_SPRITES-1 go to DONE; else i++ and dispatch.
- **DONE (1 cycle):** pulse `frame_done`, go to IDLE.
- **Address arithmetic:**
  - Sums are computed in X_W+1 / Y_W+1 bits; no wrap-around.
  - A pixel with sum ≥ SCREEN_W or ≥ SCREEN_H is issued with `plot`=0, and x/y hold the truncated sum.
  - The scan still spends the cycle on a clipped pixel.
- **Overlap:** sprites are handled strictly in index order, so a higher index overwrites a lower one in the same frame. Erasing sprite j may blank part of sprite i<j; this is accepted.
- **`enable` falling mid-frame:** the current frame completes.
- **Overrun:** a tick while busy is dropped, sets `overrun`, and does not restart the frame.
- **Reset:**
  - Asserting `reset_n` low at any time returns to IDLE and clears fcnt, `drawn[]`, `old_*`, `new_*` and `overrun`.
  - Pixels already written to the framebuffer are not erased.

## Timing
- **Reset values:** all outputs are 0: `x`, `y`, `colour`, `plot`, `busy`, `frame_done`, `overrun`.
- **Registered outputs:** all outputs are registered. `x`/`y`/`colour`/`plot` change together.
- **Latency:**
  - tick in cycle T → LATCH in T+1 (`busy`=1).
  - First ERASE/DRAW pixel is presented in T+2.
- **Frame length:** 1 (LATCH) + Σ over sprites of (E_i + D_i)·SPR_W·SPR_H + NUM_SPRITES (NEXT cycles) + 1 (DONE).
  - E_i = `drawn[i]` at frame start.
  - D_i = `new_valid[i]`.
  - `frame_done` is high in the DONE cycle.
  - `busy` falls the cycle after DONE.
- **Output spacing:** `plot` is never high outside ERASE/DRAW. Consecutive pixels are issued on consecutive clocks with no gaps.
- **Input timing:** inputs may change at any time; only their values in the LATCH cycle matter.

## Test plan
- **First frame, no prior draw:** FRAME_DIV=100, NUM_SPRITES=2, sprite0=(10,20,colour 3,valid), sprite1 invalid.
  - Expect 64 `plot` pulses covering x 10..17, y 20..27, colour 3.
  - `frame_done` exactly 1+64+2+1=68 cycles after tick.
- **Move:** next frame with sprite0=(12,20).
  - Expect 64 pixels in colour 0 at x 10..17, then 64 pixels in colour 3 at x 12..19.
  - 1+128+2+1 cycles total.
- **Clipping:** sprite0=(156,116).
  - Only 16 pulses with `plot`=1 (x 156..159, y 116..119).
  - Frame length is still 1+64+2+1 cycles.
- **Invalidate:** sprite0 drawn, then `sprite_valid[0]`=0.
  - Next frame issues only the 64-pixel erase.
  - The following frame has no `plot` pulses and lasts 1+2+1 cycles.
- **Overrun:** FRAME_DIV=50 with both sprites valid and drawn (frame ≥ 260 cycles).
  - `overrun` goes to 1 at the first overlapping tick and stays 1.
  - The frame is not restarted.
- **Reset mid-DRAW:** assert `reset_n`=0 during DRAW.
  - All outputs are 0 in the same cycle.
  - After release, the first frame draws without an erase phase.
